// File: rtl/csi2tx_dphy_clk_lp_tx_pkg.sv
// csi2tx_dphy_clk_lp_tx_pkg: shared types and constants for the D-PHY
// clock-lane LP transmitter.
// Holds the 4-bit state encoding, LP line levels {cp,cn}, default timings
// and the registered output bundle.
// ULPS states exist only when CSI2TX_DPHY_CLK_ULPS_EN is defined.
package csi2tx_dphy_clk_lp_tx_pkg;

   typedef enum logic [3:0] {
      ST_STOP      = 4'd0,
      ST_HS_RQST   = 4'd1,
      ST_HS_PREP   = 4'd2,
      ST_HS_ZERO   = 4'd3,
      ST_HS_PRE    = 4'd4,
      ST_HS_ACTIVE = 4'd5,
      ST_HS_POST   = 4'd6,
      ST_HS_TRAIL  = 4'd7,
      ST_HS_EXIT   = 4'd8
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
      ,
      ST_ULPS_RQST = 4'd9,
      ST_ULPS      = 4'd10,
      ST_ULPS_WAKE = 4'd11
`endif
   } clk_lp_state_t;

   // LP line levels packed as {cp, cn}
   localparam logic [1:0] LP11 = 2'b11;
   localparam logic [1:0] LP10 = 2'b10;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP00 = 2'b00;

   localparam int unsigned DEF_T_LPX         = 2;
   localparam int unsigned DEF_T_CLK_PREPARE = 2;
   localparam int unsigned DEF_T_CLK_ZERO    = 8;
   localparam int unsigned DEF_T_CLK_PRE     = 2;
   localparam int unsigned DEF_T_CLK_POST    = 4;
   localparam int unsigned DEF_T_CLK_TRAIL   = 2;
   localparam int unsigned DEF_T_HS_EXIT     = 4;
   localparam int unsigned DEF_T_WAKEUP      = 16;
   localparam int          DEF_CNT_W         = 16;

   typedef struct packed {
      logic [1:0] lp;
      logic       lp_en;
      logic       hs_en;
      logic       clk_en;
      logic       clk_rdy;
      logic       stop;
      logic       ulpsn;
   } clk_lp_out_t;

   localparam clk_lp_out_t OUT_RST = '{
      lp:      LP11,
      lp_en:   1'b1,
      hs_en:   1'b0,
      clk_en:  1'b0,
      clk_rdy: 1'b0,
      stop:    1'b1,
      ulpsn:   1'b1
   };

endpackage

// File: rtl/csi2tx_dphy_clk_lane_lp_txr_if.sv
// csi2tx_dphy_clk_lane_lp_txr_if: PPI requests from the controller and
// line/driver controls back from the clock-lane LP transmitter.
// Modport master = PPI/controller side, slave = the lane FSM.
interface csi2tx_dphy_clk_lane_lp_txr_if;

   logic txrequesths;
   logic txulpsclk;
   logic txulpsexit;
   logic lp_tx_cp_clk;
   logic lp_tx_cn_clk;
   logic lp_tx_cntrl_clk;
   logic hs_tx_cntrl_clk;
   logic hs_clk_en;
   logic hs_clk_ready;
   logic stopstate;
   logic ulpsactivenot;

   modport master (
      output txrequesths, txulpsclk, txulpsexit,
      input  lp_tx_cp_clk, lp_tx_cn_clk,
      input  lp_tx_cntrl_clk, hs_tx_cntrl_clk,
      input  hs_clk_en, hs_clk_ready,
      input  stopstate, ulpsactivenot
   );

   modport slave (
      input  txrequesths, txulpsclk, txulpsexit,
      output lp_tx_cp_clk, lp_tx_cn_clk,
      output lp_tx_cntrl_clk, hs_tx_cntrl_clk,
      output hs_clk_en, hs_clk_ready,
      output stopstate, ulpsactivenot
   );

endinterface

// File: rtl/csi2tx_dphy_lp_timer.sv
// csi2tx_dphy_lp_timer: loadable down-counter, saturating at zero.
// Ports: txclkesc/txescclk_rst, load + load_val, count, done (count == 0).
module csi2tx_dphy_lp_timer #(
   parameter int CNT_W = 16
) (
   input  logic             txclkesc,
   input  logic             txescclk_rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge txclkesc or posedge txescclk_rst) begin
      if (txescclk_rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign count = cnt_q;
   assign done  = (cnt_q == '0);

endmodule

// File: rtl/csi2tx_dphy_clk_lane_lp_txr.sv
// csi2tx_dphy_clk_lane_lp_txr: D-PHY clock-lane LP transmitter FSM.
// Ports: txclkesc, txescclk_rst (async, high), master, ppi (slave modport:
// PPI requests in; LP cp/cn, LP/HS driver enables, hs_clk_en,
// hs_clk_ready, stopstate, ulpsactivenot out).
// Define CSI2TX_DPHY_CLK_ULPS_EN to build the ULPS entry/exit path.
module csi2tx_dphy_clk_lane_lp_txr
   import csi2tx_dphy_clk_lp_tx_pkg::*;
#(
   parameter int unsigned T_LPX         = DEF_T_LPX,
   parameter int unsigned T_CLK_PREPARE = DEF_T_CLK_PREPARE,
   parameter int unsigned T_CLK_ZERO    = DEF_T_CLK_ZERO,
   parameter int unsigned T_CLK_PRE     = DEF_T_CLK_PRE,
   parameter int unsigned T_CLK_POST    = DEF_T_CLK_POST,
   parameter int unsigned T_CLK_TRAIL   = DEF_T_CLK_TRAIL,
   parameter int unsigned T_HS_EXIT     = DEF_T_HS_EXIT,
   parameter int unsigned T_WAKEUP      = DEF_T_WAKEUP,
   parameter int          CNT_W         = DEF_CNT_W
) (
   input logic                          txclkesc,
   input logic                          txescclk_rst,
   input logic                          master,
   csi2tx_dphy_clk_lane_lp_txr_if.slave ppi
);

   clk_lp_state_t    st_q, st_d;
   clk_lp_out_t      out_q, out_d;
   logic             tmr_load, tmr_done;
   logic [CNT_W-1:0] tmr_val, tmr_cnt_unused;

   // Timer preload for the state being entered; untimed states load 0.
   function automatic logic [CNT_W-1:0] tload(clk_lp_state_t s);
      unique case (s)
         ST_HS_RQST:   return CNT_W'(T_LPX - 1);
         ST_HS_PREP:   return CNT_W'(T_CLK_PREPARE - 1);
         ST_HS_ZERO:   return CNT_W'(T_CLK_ZERO - 1);
         ST_HS_PRE:    return CNT_W'(T_CLK_PRE - 1);
         ST_HS_POST:   return CNT_W'(T_CLK_POST - 1);
         ST_HS_TRAIL:  return CNT_W'(T_CLK_TRAIL - 1);
         ST_HS_EXIT:   return CNT_W'(T_HS_EXIT - 1);
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
         ST_ULPS_RQST: return CNT_W'(T_LPX - 1);
         ST_ULPS_WAKE: return CNT_W'(T_WAKEUP - 1);
`endif
         default:      return '0;
      endcase
   endfunction

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         ST_STOP: begin
            if (ppi.txrequesths) st_d = ST_HS_RQST;
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
            else if (ppi.txulpsclk) st_d = ST_ULPS_RQST;
`endif
         end
         ST_HS_RQST:   if (tmr_done) st_d = ST_HS_PREP;
         ST_HS_PREP:   if (tmr_done) st_d = ST_HS_ZERO;
         ST_HS_ZERO:   if (tmr_done) st_d = ST_HS_PRE;
         ST_HS_PRE:    if (tmr_done) st_d = ST_HS_ACTIVE;
         ST_HS_ACTIVE: if (!ppi.txrequesths) st_d = ST_HS_POST;
         ST_HS_POST:   if (tmr_done) st_d = ST_HS_TRAIL;
         ST_HS_TRAIL:  if (tmr_done) st_d = ST_HS_EXIT;
         ST_HS_EXIT:   if (tmr_done) st_d = ST_STOP;
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
         ST_ULPS_RQST: if (tmr_done) st_d = ST_ULPS;
         ST_ULPS:      if (ppi.txulpsexit) st_d = ST_ULPS_WAKE;
         // Mark held until both the wakeup time and the request drop.
         ST_ULPS_WAKE: if (tmr_done && !ppi.txulpsclk) st_d = ST_STOP;
`endif
         default:      st_d = ST_STOP;
      endcase
      if (!master) st_d = ST_STOP;
   end

   assign tmr_load = (st_d != st_q);
   assign tmr_val  = tload(st_d);

   // Outputs decoded from the next state so they align with st_q.
   always_comb begin
      out_d = '{
         lp:      LP11,
         lp_en:   1'b1,
         hs_en:   1'b0,
         clk_en:  1'b0,
         clk_rdy: 1'b0,
         stop:    1'b0,
         ulpsn:   1'b1
      };
      unique case (st_d)
         ST_STOP:    out_d.stop = 1'b1;
         ST_HS_RQST: out_d.lp   = LP01;
         ST_HS_PREP: out_d.lp   = LP00;
         ST_HS_ZERO, ST_HS_TRAIL: begin
            out_d.lp    = LP00;
            out_d.lp_en = 1'b0;
            out_d.hs_en = 1'b1;
         end
         ST_HS_PRE, ST_HS_POST: begin
            out_d.lp     = LP00;
            out_d.lp_en  = 1'b0;
            out_d.hs_en  = 1'b1;
            out_d.clk_en = 1'b1;
         end
         ST_HS_ACTIVE: begin
            out_d.lp      = LP00;
            out_d.lp_en   = 1'b0;
            out_d.hs_en   = 1'b1;
            out_d.clk_en  = 1'b1;
            out_d.clk_rdy = 1'b1;
         end
         ST_HS_EXIT: out_d.lp = LP11;
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
         ST_ULPS_RQST: out_d.lp = LP10;
         ST_ULPS: begin
            out_d.lp    = LP00;
            out_d.ulpsn = 1'b0;
         end
         ST_ULPS_WAKE: begin
            out_d.lp    = LP10;
            out_d.ulpsn = 1'b0;
         end
`endif
         default: ;
      endcase
      if (!master) begin
         out_d.lp_en   = 1'b0;
         out_d.hs_en   = 1'b0;
         out_d.clk_en  = 1'b0;
         out_d.clk_rdy = 1'b0;
      end
   end

   always_ff @(posedge txclkesc or posedge txescclk_rst) begin
      if (txescclk_rst) begin
         st_q  <= ST_STOP;
         out_q <= OUT_RST;
      end else begin
         st_q  <= st_d;
         out_q <= out_d;
      end
   end

   csi2tx_dphy_lp_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .txclkesc     (txclkesc),
      .txescclk_rst (txescclk_rst),
      .load         (tmr_load),
      .load_val     (tmr_val),
      .count        (tmr_cnt_unused),
      .done         (tmr_done)
   );

   assign ppi.lp_tx_cp_clk    = out_q.lp[1];
   assign ppi.lp_tx_cn_clk    = out_q.lp[0];
   // Reset cannot sample master, so the LP enable is qualified here.
   assign ppi.lp_tx_cntrl_clk = out_q.lp_en & master;
   assign ppi.hs_tx_cntrl_clk = out_q.hs_en;
   assign ppi.hs_clk_en       = out_q.clk_en;
   assign ppi.hs_clk_ready    = out_q.clk_rdy;
   assign ppi.stopstate       = out_q.stop;

`ifdef CSI2TX_DPHY_CLK_ULPS_EN
   assign ppi.ulpsactivenot = out_q.ulpsn;
`else
   localparam int unsigned unused_t_wakeup = T_WAKEUP;
   logic unused_ulps;
   assign unused_ulps = ^{ppi.txulpsclk, ppi.txulpsexit,
                          out_q.ulpsn};
   assign ppi.ulpsactivenot = 1'b1;
`endif

endmodule

// File: doc/csi2tx_dphy_clk_lane_lp_txr.md
Name: csi2tx_dphy_clk_lane_lp_txr

Overview:
Clock-lane low-power transmitter FSM for the CSI-2 TX D-PHY master side, clocked by txclkesc. Sequences the clock lane through stop, the HS-clock entry/exit sequence (LP-11 → LP-01 → LP-00 → HS-0 → DDR clock → HS-0 → LP-11) and the ULPS entry/exit sequence (LP-10 → LP-00 → LP-10 → LP-11). Drives the LP CP/CN lines and the HS/LP driver enables to the transceiver. Gives the HS clock generator its enable and tells the data lanes when the DDR clock is stable.

Parameters:
T_LPX, 2, LP-01 / LP-10 request duration in txclkesc cycles (≥1)
T_CLK_PREPARE, 2, LP-00 duration before the HS driver is enabled (≥1)
T_CLK_ZERO, 8, HS-0 duration before toggling starts (≥1)
T_CLK_PRE, 2, toggling cycles before hs_clk_ready asserts (≥1)
T_CLK_POST, 4, toggling cycles kept after txrequesths falls (≥1)
T_CLK_TRAIL, 2, HS-0 trail duration (≥1)
T_HS_EXIT, 4, LP-11 hold after HS before new requests are accepted (≥1)
T_WAKEUP, 16, LP-10 mark duration on ULPS exit (≥1)
CNT_W, 16, width of the timing down-counter

Ports:
txclkesc  in  1  escape clock; only clock
txescclk_rst  in  1  asynchronous, active-high reset
master  in  1  lane configured as transmitter; 0 disables all drivers
txrequesths  in  1  PPI request for HS clock
txulpsclk  in  1  PPI ULPS entry request
txulpsexit  in  1  PPI ULPS exit request
lp_tx_cp_clk  out  1  LP driver CP level
lp_tx_cn_clk  out  1  LP driver CN level
lp_tx_cntrl_clk  out  1  LP driver enable to transceiver
hs_tx_cntrl_clk  out  1  HS driver enable to transceiver
hs_clk_en  out  1  enables DDR clock toggling in the HS serializer
hs_clk_ready  out  1  DDR clock stable; data lanes may begin SoT
stopstate  out  1  lane in LP-11 stop and idle
ulpsactivenot  out  1  active-low; lane in ULPS

Behaviour:
- Reset (async) → state STOP.
  - Reset values: cp/cn = 1/1, lp_tx_cntrl_clk = master, hs_tx_cntrl_clk = 0, hs_clk_en = 0, hs_clk_ready = 0, stopstate = 1, ulpsactivenot = 1.
  - Reset mid-sequence aborts to this state immediately.
- All outputs are registered. They are decoded from the next state and update on the same edge as the state register.
- Timer: on entry to any timed state, load parameter−1. Leave the state on the edge where count == 0, so each timed state lasts exactly N cycles.
- States, with line levels and transitions:
  - STOP (LP-11): stopstate = 1. txrequesths → HS_RQST. Else txulpsclk → ULPS_RQST. If both are high, HS wins.
  - HS_RQST (LP-01), T_LPX → HS_PREP.
  - HS_PREP (LP-00), T_CLK_PREPARE → HS_ZERO.
  - HS_ZERO: hs_tx_cntrl_clk = 1, lp_tx_cntrl_clk = 0, HS-0. T_CLK_ZERO → HS_PRE.
  - HS_PRE: hs_clk_en = 1. T_CLK_PRE → HS_ACTIVE.
  - HS_ACTIVE: hs_clk_en = 1, hs_clk_ready = 1. Stays while txrequesths = 1; on txrequesths = 0 → HS_POST.
  - HS_POST: hs_clk_en = 1, hs_clk_ready = 0. T_CLK_POST → HS_TRAIL.
  - HS_TRAIL: HS driver on, clock stopped at HS-0. T_CLK_TRAIL → HS_EXIT.
  - HS_EXIT (LP-11): LP driver on, stopstate = 0. T_HS_EXIT → STOP.
  - ULPS_RQST (LP-10), T_LPX → ULPS.
  - ULPS (LP-00): ulpsactivenot = 0. txulpsexit → ULPS_WAKE.
  - ULPS_WAKE (LP-10): ulpsactivenot = 0. After T_WAKEUP, → STOP only once txulpsclk = 0; until then it holds LP-10.
- txrequesths falling in HS_RQST..HS_PRE: no abort. The sequence reaches HS_ACTIVE, stays one cycle, then goes to HS_POST.
- txrequesths rising in HS_POST..HS_EXIT: ignored until STOP is reached.
- txulpsclk outside STOP, and txulpsexit outside ULPS: ignored.
- master = 0: synchronous forced return to STOP; all driver enables 0; hs_clk_en = 0.
- The timer never wraps. It saturates at 0 in untimed states.

Optional Feature:
CSI2TX_DPHY_CLK_ULPS_EN
- Defined: the ULPS path is present as described.
- Undefined: ULPS_RQST, ULPS and ULPS_WAKE are removed; txulpsclk and txulpsexit are ignored; ulpsactivenot is tied to 1.

Decomposition:
- Package csi2tx_dphy_clk_lp_tx_pkg holds:
  - state encoding constants (4-bit);
  - LP line-state constants LP11, LP10, LP01, LP00;
  - default timing constants.
- Sub-module csi2tx_dphy_lp_timer: loadable CNT_W down-counter with a done flag. It is reusable by the data-lane LP transmitter.

Test Plan:
1. Reset released, master = 1, all requests 0 → cp/cn = 11, stopstate = 1, lp_tx_cntrl_clk = 1, everything else 0.
2. txrequesths = 1 at cycle 0 with defaults → LP-01 for 2 cycles, LP-00 for 2, hs_tx_cntrl_clk from cycle 5, hs_clk_en from cycle 13, hs_clk_ready from cycle 15.
3. Drop txrequesths in HS_ACTIVE → hs_clk_ready falls next edge, hs_clk_en lasts 4 more cycles, HS-0 for 2, LP-11 with stopstate = 0 for 4, then stopstate = 1.
4. txulpsclk = 1 → LP-10 for 2 cycles, LP-00 with ulpsactivenot = 0. Then txulpsexit = 1 → LP-10 for 16 cycles. Hold txulpsclk = 1 for 5 more cycles → LP-10 persists. After txulpsclk = 0 → LP-11.
5. txrequesths and txulpsclk asserted in the same cycle in STOP → HS sequence taken, ULPS never entered. Pulse txrequesths for 1 cycle only → full sequence; HS_ACTIVE lasts exactly 1 cycle.
6. Assert txescclk_rst during HS_ZERO, and separately master = 0 during HS_ACTIVE → immediate/next-edge return to LP-11 with hs_tx_cntrl_clk = 0 and hs_clk_en = 0.
